axi_wr_slave: RTL and testbench

// - AXI4 write-channel slave front end. Consumes aw_t/w_t from axi_defines and produces b_t.
// - Turns each burst into single-cycle word writes on a simple SRAM port (RISC-V data/instr RAM).
// - Sits directly downstream of the interconnect/master that drives the AXI write channels.

---
 rtl/axi_wr_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi_wr_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave.sv
//------------------------------------------------------------------------------
// Module      : axi_wr_slave (with package axi_defines)
// Description : AXI4 write-channel slave turning bursts into single-word SRAM
//               writes. Define AXI_WRAP_EN to build WRAP burst support.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package axi_defines;
    typedef struct packed {
        logic        valid;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
    } aw_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [3:0]  strb;
        logic [31:0] data;
    } w_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  resp;
    } b_t;

    localparam logic [1:0] c_burst_fixed = 2'd0;
    localparam logic [1:0] c_burst_incr  = 2'd1;
    localparam logic [1:0] c_burst_wrap  = 2'd2;
    localparam logic [1:0] c_burst_rsvd  = 2'd3;

    localparam logic [1:0] c_resp_okay   = 2'd0;
    localparam logic [1:0] c_resp_slverr = 2'd2;
    localparam logic [1:0] c_resp_decerr = 2'd3;
endpackage

module axi_wr_slave
    import axi_defines::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  aw_t               aw,
    output logic              aw_ready,
    input  w_t                w,
    output logic              w_ready,
    output b_t                b,
    input  logic              b_ready,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be
);

    localparam logic [1:0]  c_idle = 2'd0;
    localparam logic [1:0]  c_data = 2'd1;
    localparam logic [1:0]  c_resp = 2'd2;
    localparam logic [33:0] c_win  = 34'd1 << ADDR_W;

    logic [1:0]  r_state, w_next_state;
    logic        r_aw_ready, r_w_ready, r_b_valid;
    logic [1:0]  r_burst;
    logic [2:0]  r_size;
    logic [7:0]  r_len, r_beat_cnt;
    logic [31:0] r_cur_addr;
    logic [1:0]  r_err;
    logic        r_proto_err;

    logic        w_aw_hs, w_w_hs, w_b_hs, w_last_beat;
    logic [31:0] w_aw_step, w_aw_bytes, w_lo, w_ext;
    logic [33:0] w_start_off, w_end_off;
    logic        w_wrap_bad;
    logic [1:0]  w_aw_err, w_resp;
    logic [31:0] w_step, w_next_addr;
`ifdef AXI_WRAP_EN
    logic [31:0] w_bound;
`endif

    assign w_aw_hs     = aw.valid & r_aw_ready;
    assign w_w_hs      = w.valid & r_w_ready;
    assign w_b_hs      = r_b_valid & b_ready;
    assign w_last_beat = (r_beat_cnt == r_len);

    // Decode error for the incoming AW; DECERR outranks SLVERR.
    always_comb begin
        w_aw_step  = 32'd1 << aw.size;
        w_aw_bytes = ({24'd0, aw.len} + 32'd1) << aw.size;
        w_lo       = aw.addr;
        w_ext      = w_aw_bytes;
        if (aw.burst == c_burst_fixed) begin
            w_ext = w_aw_step;
            w_lo  = aw.addr & ~(w_aw_step - 32'd1);
        end else if (aw.burst == c_burst_wrap) begin
            w_lo  = aw.addr & ~(w_aw_bytes - 32'd1);
        end
        w_start_off = {2'b00, aw.addr} - {2'b00, BASE_ADDR};
        w_end_off   = {2'b00, w_lo} - {2'b00, BASE_ADDR} + {2'b00, w_ext} - 34'd1;
`ifdef AXI_WRAP_EN
        w_wrap_bad  = (aw.burst == c_burst_wrap) &&
                      !(aw.len == 8'd1 || aw.len == 8'd3 || aw.len == 8'd7 || aw.len == 8'd15);
`else
        w_wrap_bad  = (aw.burst == c_burst_wrap);
`endif
        if (w_start_off >= c_win || w_end_off >= c_win)
            w_aw_err = c_resp_decerr;
        else if (aw.size > 3'd2 || aw.burst == c_burst_rsvd || w_wrap_bad)
            w_aw_err = c_resp_slverr;
        else
            w_aw_err = c_resp_okay;
    end

    always_comb begin
        w_step      = 32'd1 << r_size;
        w_next_addr = r_cur_addr;
`ifdef AXI_WRAP_EN
        w_bound     = ({24'd0, r_len} + 32'd1) << r_size;
`endif
        case (r_burst)
            c_burst_incr: w_next_addr = r_cur_addr + w_step;
`ifdef AXI_WRAP_EN
            c_burst_wrap: w_next_addr = (r_cur_addr & ~(w_bound - 32'd1)) |
                                        ((r_cur_addr + w_step) & (w_bound - 32'd1));
`endif
            default:      w_next_addr = r_cur_addr;
        endcase
    end

    // State register; ready/valid flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_aw_ready <= (w_next_state == c_idle);
            r_w_ready  <= (w_next_state == c_data);
            r_b_valid  <= (w_next_state == c_resp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst     <= 2'd0;
            r_size      <= 3'd0;
            r_len       <= 8'd0;
            r_cur_addr  <= 32'd0;
            r_beat_cnt  <= 8'd0;
            r_err       <= c_resp_okay;
            r_proto_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_burst     <= aw.burst;
            r_size      <= aw.size;
            r_len       <= aw.len;
            r_cur_addr  <= aw.addr;
            r_beat_cnt  <= 8'd0;
            r_err       <= w_aw_err;
            r_proto_err <= 1'b0;
        end else if (w_w_hs) begin
            r_cur_addr  <= w_next_addr;
            r_beat_cnt  <= r_beat_cnt + 8'd1;
            if (w.last != w_last_beat && r_err == c_resp_okay)
                r_proto_err <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_aw_hs) w_next_state = c_data;
            c_data:  if (w_w_hs && w_last_beat) w_next_state = c_resp;
            c_resp:  if (w_b_hs) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Protocol errors do not block writes; only the AW decode result does.
    always_comb begin
        w_resp    = (r_err != c_resp_okay) ? r_err :
                    (r_proto_err ? c_resp_slverr : c_resp_okay);
        aw_ready  = r_aw_ready;
        w_ready   = r_w_ready;
        b.valid   = r_b_valid;
        b.resp    = r_b_valid ? w_resp : c_resp_okay;
        mem_we    = w_w_hs & (r_err == c_resp_okay);
        mem_addr  = (ADDR_W-2)'((r_cur_addr - BASE_ADDR) >> 2);
        mem_wdata = w.data;
        mem_be    = w.strb;
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_slave.sv
//------------------------------------------------------------------------------
// Module      : tb_axi_wr_slave
// Description : Directed self-checking bench for axi_wr_slave with a burst model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axi_wr_slave;
    import axi_defines::*;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam longint      BASE_L = 64'h0001_0000;
    localparam int          AWB    = 16;
    localparam longint      WIN    = 64'd1 << AWB;
`ifdef AXI_WRAP_EN
    localparam bit c_wrap_en = 1'b1;
`else
    localparam bit c_wrap_en = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    aw_t             aw;
    w_t              w;
    b_t              b;
    logic            aw_ready, w_ready, b_ready, mem_we;
    logic [AWB-3:0]  mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_be;

    always #5 clk = ~clk;

    axi_wr_slave #(.BASE_ADDR(BASE), .ADDR_W(AWB)) dut (
        .clk(clk), .rst_n(rst_n), .aw(aw), .aw_ready(aw_ready), .w(w), .w_ready(w_ready),
        .b(b), .b_ready(b_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be)
    );

    typedef struct { logic [31:0] waddr; logic [31:0] data; logic [3:0] be; } wr_t;
    wr_t        exp_q[$];
    logic [1:0] exp_resp;
    bit         exp_ok = 1'b0;
    int         exp_n, writes_seen;
    int         total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] dbase, input int i);
        return dbase + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] beat_be(input int i);
        return (i % 2 == 1) ? 4'h3 : 4'hF;
    endfunction

    // Expected writes and response derived from the burst rules with plain arithmetic.
    task automatic model_burst(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size,
                               input logic [7:0] len, input logic [15:0] last_mask, input logic [31:0] dbase);
        longint a, step, span, lowb, hi, ba;
        bit     dec, slv, proto;
        int     nb;
        wr_t    e;
        a    = longint'(addr);
        step = longint'(1) << size;
        nb   = int'(len) + 1;
        span = step * nb;
        if (burst == c_burst_fixed) begin
            lowb = (a / step) * step; hi = lowb + step - 1;
        end else if (burst == c_burst_wrap) begin
            lowb = (a / span) * span; hi = lowb + span - 1;
        end else begin
            lowb = a; hi = a + span - 1;
        end
        dec = (a < BASE_L) || (a >= BASE_L + WIN) || (hi >= BASE_L + WIN);
        slv = (size > 3'd2) || (burst == 2'd3) ||
              (burst == c_burst_wrap && (!c_wrap_en || !(len inside {8'd1, 8'd3, 8'd7, 8'd15})));
        proto = 1'b0;
        for (int i = 0; i < nb; i++)
            if (last_mask[i] != (i == nb - 1)) proto = 1'b1;
        exp_resp = dec ? 2'd3 : (slv ? 2'd2 : (proto ? 2'd2 : 2'd0));
        exp_ok   = !dec && !slv;
        exp_q.delete();
        if (exp_ok) begin
            for (int i = 0; i < nb; i++) begin
                if (burst == c_burst_fixed)     ba = a;
                else if (burst == c_burst_wrap) ba = lowb + ((a - lowb) + i * step) % span;
                else                            ba = a + i * step;
                e.waddr = 32'(((ba - BASE_L) / 4) % (WIN / 4));
                e.data  = beat_data(dbase, i);
                e.be    = beat_be(i);
                exp_q.push_back(e);
            end
        end
        exp_n = exp_q.size();
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size,
                             input logic [7:0] len, input logic [15:0] last_mask, input logic [31:0] dbase,
                             input int gap, input bit early_w, input int b_delay);
        int n;
        model_burst(addr, burst, size, len, last_mask, dbase);
        writes_seen = 0;
        @(negedge clk);
        aw.valid = 1'b1; aw.burst = burst; aw.size = size; aw.len = len; aw.addr = addr;
        if (early_w) begin
            w.valid = 1'b1; w.data = beat_data(dbase, 0); w.strb = beat_be(0); w.last = last_mask[0];
            chk("w_stall_in_idle", {63'd0, w_ready}, 64'd0);
        end
        n = 0;
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            timed_out("aw_handshake");
            aw.valid = 1'b0; w.valid = 1'b0;
            return;
        end
        @(negedge clk);
        aw.valid = 1'b0;
        chk("aw_ready_in_data", {63'd0, aw_ready}, 64'd0);
        for (int i = 0; i <= int'(len); i++) begin
            if (gap > 0 && i % 2 == 1) begin
                w.valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            w.valid = 1'b1; w.data = beat_data(dbase, i); w.strb = beat_be(i); w.last = last_mask[i];
            n = 0;
            while (!w_ready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin
                timed_out("w_handshake");
                w.valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        w.valid = 1'b0;
        chk("write_count", 64'(writes_seen), 64'(exp_n));
        chk("writes_left", 64'(exp_q.size()), 64'd0);
        n = 0;
        while (!b.valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            timed_out("b_valid");
            return;
        end
        chk("b_resp", {62'd0, b.resp}, {62'd0, exp_resp});
        repeat (b_delay) begin
            @(negedge clk);
            chk("b_hold_valid", {63'd0, b.valid}, 64'd1);
            chk("b_hold_resp", {62'd0, b.resp}, {62'd0, exp_resp});
            chk("aw_ready_in_resp", {63'd0, aw_ready}, 64'd0);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("b_valid_after_hs", {63'd0, b.valid}, 64'd0);
        chk("aw_ready_after_hs", {63'd0, aw_ready}, 64'd1);
    endtask

    // Write-port comparator, sampled mid-low-phase so inputs and outputs are settled.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (mem_we) begin
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: addr %0h data %0h", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_addr", 64'(mem_addr), 64'(e.waddr));
                        chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
                        chk("mem_be", 64'(mem_be), 64'(e.be));
                    end
                end else if (w.valid && w_ready && exp_ok) begin
                    chk("mem_we_missing", {63'd0, mem_we}, 64'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aw = '0; w = '0; b_ready = 1'b0;
        #1 rst_n = 1'b0;
        aw.valid = 1'b1; aw.burst = c_burst_incr; aw.size = 3'd2; aw.addr = BASE;
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
        chk("rst_w_ready", {63'd0, w_ready}, 64'd0);
        chk("rst_b_valid", {63'd0, b.valid}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        rst_n = 1'b1;
        aw.valid = 1'b0;
        chk("aw_ready_at_release", {63'd0, aw_ready}, 64'd0);
        @(negedge clk);
        chk("aw_ready_after_release", {63'd0, aw_ready}, 64'd1);

        // Single INCR beat.
        model_burst(BASE + 32'h10, c_burst_incr, 3'd2, 8'd0, 16'h0001, 32'hDEAD_BEEF);
        chk("pin_single_addr", 64'(exp_q[0].waddr), 64'd4);
        chk("pin_single_data", 64'(exp_q[0].data), 64'hDEAD_BEEF);
        run_burst(BASE + 32'h10, c_burst_incr, 3'd2, 8'd0, 16'h0001, 32'hDEAD_BEEF, 0, 1'b0, 0);

        // INCR len=3 with gaps and W presented before AW.
        model_burst(BASE + 32'h20, c_burst_incr, 3'd2, 8'd3, 16'h0008, 32'h1000_0000);
        chk("pin_incr_a0", 64'(exp_q[0].waddr), 64'd8);
        chk("pin_incr_a3", 64'(exp_q[3].waddr), 64'd11);
        run_burst(BASE + 32'h20, c_burst_incr, 3'd2, 8'd3, 16'h0008, 32'h1000_0000, 2, 1'b1, 0);

        // WRAP len=3 starting mid-window.
        model_burst(BASE + 32'h38, c_burst_wrap, 3'd2, 8'd3, 16'h0008, 32'h2000_0000);
`ifdef AXI_WRAP_EN
        chk("pin_wrap_a1", 64'(exp_q[1].waddr), 64'd15);
        chk("pin_wrap_a2", 64'(exp_q[2].waddr), 64'd12);
`else
        chk("pin_wrap_nowrites", 64'(exp_q.size()), 64'd0);
        chk("pin_wrap_resp", 64'(exp_resp), 64'd2);
`endif
        run_burst(BASE + 32'h38, c_burst_wrap, 3'd2, 8'd3, 16'h0008, 32'h2000_0000, 0, 1'b0, 0);

        // Burst running off the top of the window.
        model_burst(BASE + 32'hFFFC, c_burst_incr, 3'd2, 8'd1, 16'h0002, 32'h3000_0000);
        chk("pin_oow_resp", 64'(exp_resp), 64'd3);
        run_burst(BASE + 32'hFFFC, c_burst_incr, 3'd2, 8'd1, 16'h0002, 32'h3000_0000, 0, 1'b0, 2);

        // Early w.last, response held for 5 cycles.
        model_burst(BASE + 32'h80, c_burst_incr, 3'd2, 8'd2, 16'h0002, 32'h4000_0000);
        chk("pin_proto_resp", 64'(exp_resp), 64'd2);
        chk("pin_proto_writes", 64'(exp_n), 64'd3);
        run_burst(BASE + 32'h80, c_burst_incr, 3'd2, 8'd2, 16'h0002, 32'h4000_0000, 0, 1'b0, 5);

        run_burst(BASE + 32'h44,  c_burst_fixed, 3'd2, 8'd2, 16'h0004, 32'h5000_0000, 1, 1'b0, 0);
        run_burst(BASE + 32'h101, c_burst_incr,  3'd0, 8'd3, 16'h0008, 32'h6000_0000, 0, 1'b0, 0);
        run_burst(BASE + 32'h40,  c_burst_incr,  3'd3, 8'd0, 16'h0001, 32'h7000_0000, 0, 1'b0, 0);
        run_burst(BASE - 32'h4,   c_burst_incr,  3'd2, 8'd0, 16'h0001, 32'h8000_0000, 0, 1'b0, 0);
        run_burst(BASE + 32'h50,  2'd3,          3'd2, 8'd1, 16'h0002, 32'h9000_0000, 0, 1'b0, 0);
        run_burst(BASE + 32'h60,  c_burst_wrap,  3'd2, 8'd2, 16'h0004, 32'hA000_0000, 0, 1'b0, 1);
        run_burst(BASE + 32'h200, c_burst_incr,  3'd2, 8'd7, 16'h0080, 32'hB000_0000, 1, 1'b1, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
